vga_fb_arbiter: RTL and testbench

- Owns the single-port pixel framebuffer RAM and shares it between two users:
  - VGA scan-out, driven by the VGA_Driver x / y / blanking outputs;
  - a drawing-engine write port with a valid/ready handshake.
- Scan-out reads have absolute priority.
- Writes and a built-in framebuffer clear sequencer use every RAM cycle that scan-out does not need.
- Sits between VGA_Driver, the BRAM framebuffer and the colour output pins.

---
 rtl/vga_fb_arbiter.sv | 140 ++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter.sv
// -----------------------------------------------------------------------------
// vga_fb_arbiter
//   Owns the single-port pixel framebuffer RAM and shares it between VGA
//   scan-out (absolute priority), a built-in full-buffer clear sequencer and a
//   drawing-engine write port. Also produces the colour output for the DAC.
//
// Ports
//   clk, rst        pixel clock, synchronous active-high reset
//   blanking, x, y  raster position from VGA_Driver (blanking=1 outside active)
//   wr_valid/ready  drawing-engine write handshake (wr_ready is combinational)
//   wr_addr/data    linear framebuffer address and pixel
//   clear_req       one-cycle pulse starting a clear with clear_color
//   clear_busy      clear in progress
//   mem_*           single-port RAM interface; mem_rdata has 1-cycle latency
//   rgb             pixel to the DAC, one clock behind x/y/blanking
// -----------------------------------------------------------------------------
module vga_fb_arbiter #(
  parameter int FB_W        = 160,
  parameter int FB_H        = 120,
  parameter int SCALE_SHIFT = 2,
  parameter int ADDR_W      = 15,
  parameter int PIX_W       = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              blanking,
  input  logic [9:0]        x,
  input  logic [8:0]        y,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic              clear_req,
  input  logic [PIX_W-1:0]  clear_color,
  output logic              clear_busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [PIX_W-1:0]  mem_wdata,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic [PIX_W-1:0]  rgb
);

  localparam int                FB_N    = FB_W * FB_H;
  localparam logic [ADDR_W-1:0] FB_LAST = ADDR_W'(FB_N - 1);

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [PIX_W-1:0]  clr_color_q, clr_color_d;
  logic              blank_q, scan_rd_q;
  logic [PIX_W-1:0]  held_q;

  logic              scan_need;
  logic [9:0]        fb_x;
  logic [8:0]        fb_y;
  logic [ADDR_W-1:0] scan_addr;

  // One RAM read per group of 2^SCALE_SHIFT screen columns; the pixel is then
  // held for the rest of the group.
  assign scan_need = ~blanking & (x[SCALE_SHIFT-1:0] == '0);
  assign fb_x      = x >> SCALE_SHIFT;
  assign fb_y      = y >> SCALE_SHIFT;
  assign scan_addr = ADDR_W'(int'(fb_y) * FB_W + int'(fb_x));

  // Slot arbitration and clear sequencing.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    clr_color_d = clr_color_q;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    wr_ready    = 1'b0;

    if (scan_need) begin
      mem_en   = 1'b1;
      mem_addr = scan_addr;
    end else if (state_q == CLEAR) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = clr_cnt_q;
      mem_wdata = clr_color_q;
      // Counter only advances on slots the clear actually owns.
      if (clr_cnt_q == FB_LAST) begin
        state_d   = IDLE;
        clr_cnt_d = '0;
      end else begin
        clr_cnt_d = clr_cnt_q + 1'b1;
      end
    end else if (wr_valid) begin
      // Out-of-range writes are acknowledged but dropped.
      wr_ready  = 1'b1;
      mem_en    = 1'b1;
      mem_we    = (wr_addr <= FB_LAST);
      mem_addr  = wr_addr;
      mem_wdata = wr_data;
    end

    // A request while already clearing is ignored.
    if (state_q == IDLE && clear_req) begin
      state_d     = CLEAR;
      clr_cnt_d   = '0;
      clr_color_d = clear_color;
    end

    if (rst) begin
      mem_en   = 1'b0;
      mem_we   = 1'b0;
      wr_ready = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      clr_cnt_q   <= '0;
      clr_color_q <= '0;
      blank_q     <= 1'b1;
      scan_rd_q   <= 1'b0;
      held_q      <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      clr_color_q <= clr_color_d;
      blank_q     <= blanking;
      scan_rd_q   <= scan_need;
      if (scan_rd_q) held_q <= mem_rdata;
    end
  end

  assign clear_busy = (state_q == CLEAR);

  // mem_rdata is only valid the cycle after a scan read; otherwise replay the
  // held pixel.
  assign rgb = blank_q ? '0 : (scan_rd_q ? mem_rdata : held_q);

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vga_fb_arbiter
//   Randomized bench with a framebuffer-level reference model. Each stimulus
//   cycle pushes the expected outputs into a queue; a negedge monitor pops and
//   compares. The RAM below is the environment's BRAM, not a model.
// -----------------------------------------------------------------------------
module tb_vga_fb_arbiter;

  localparam int FB_W = 160;
  localparam int FB_H = 120;
  localparam int FB_N = FB_W * FB_H;

  logic        clk = 1'b0;
  logic        rst, blanking, wr_valid, wr_ready, clear_req, clear_busy;
  logic [9:0]  x;
  logic [8:0]  y;
  logic [14:0] wr_addr, mem_addr;
  logic [11:0] wr_data, clear_color, mem_wdata, mem_rdata, rgb;
  logic        mem_en, mem_we;

  vga_fb_arbiter dut (
    .clk(clk), .rst(rst), .blanking(blanking), .x(x), .y(y),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .clear_req(clear_req), .clear_color(clear_color),
    .clear_busy(clear_busy), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .rgb(rgb)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] pat(int i);
    if (i == 0) return 12'hF00;
    if (i == 1) return 12'h0F0;
    return 12'((i * 37) ^ 'h5A5);
  endfunction

  // Synchronous single-port BRAM, read-first, loaded on the first edge.
  logic [11:0] ram [0:32767];
  bit          ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 32768; i++) ram[i] <= pat(i);
      ram_init <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  typedef struct {
    int          cyc;
    logic [11:0] rgb;
    bit          ready, busy, en, we;
    logic [14:0] addr;
    logic [11:0] wdata;
  } exp_t;

  exp_t q[$];
  int   checks = 0, errors = 0;
  int   cyc = 0, mon_cyc = 0;

  // Reference model state: what the framebuffer should contain and what the
  // screen should show.
  logic [11:0] ref_fb [0:FB_N-1];
  bit          m_busy = 0;
  int          m_cnt = 0;
  logic [11:0] m_color = '0, m_held = '0, exp_rgb = '0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  always @(posedge clk) mon_cyc <= mon_cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc < mon_cyc) void'(q.pop_front());
    if (q.size() > 0 && q[0].cyc == mon_cyc) begin
      e = q.pop_front();
      chk("rgb", 32'(rgb), 32'(e.rgb));
      chk("wr_ready", 32'(wr_ready), 32'(e.ready));
      chk("clear_busy", 32'(clear_busy), 32'(e.busy));
      chk("mem_en", 32'(mem_en), 32'(e.en));
      if (e.en) begin
        chk("mem_we", 32'(mem_we), 32'(e.we));
        chk("mem_addr", 32'(mem_addr), 32'(e.addr));
      end
      if (e.we) chk("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
    end
  end

  // Predict this cycle's outputs from the current inputs, advance the model,
  // then clock.
  task automatic cycle();
    exp_t e;
    bit   was_busy;
    int   sa;
    e.cyc = cyc; e.rgb = exp_rgb; e.busy = m_busy;
    e.ready = 0; e.en = 0; e.we = 0; e.addr = '0; e.wdata = '0;
    was_busy = m_busy;
    if (rst) begin
      m_busy = 0; m_cnt = 0; m_held = '0; exp_rgb = '0;
    end else begin
      if (!blanking && (int'(x) % 4 == 0)) begin
        sa = (int'(y) / 4) * FB_W + int'(x) / 4;
        e.en = 1; e.addr = 15'(sa);
        m_held = ref_fb[sa];
      end else if (m_busy) begin
        e.en = 1; e.we = 1; e.addr = 15'(m_cnt); e.wdata = m_color;
        ref_fb[m_cnt] = m_color;
        if (m_cnt == FB_N - 1) begin m_busy = 0; m_cnt = 0; end
        else m_cnt++;
      end else if (wr_valid) begin
        e.ready = 1; e.en = 1; e.addr = wr_addr; e.wdata = wr_data;
        if (int'(wr_addr) < FB_N) begin
          e.we = 1;
          ref_fb[wr_addr] = wr_data;
        end
      end
      if (!was_busy && clear_req) begin
        m_busy = 1; m_cnt = 0; m_color = clear_color;
      end
      exp_rgb = blanking ? 12'h000 : m_held;
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic rand_wr();
    wr_valid = 1'($urandom_range(0, 1));
    wr_addr  = 15'($urandom_range(0, FB_N + 100));
    wr_data  = 12'($urandom);
  endtask

  task automatic ram_vs_ref(string nm);
    int bad = 0;
    for (int i = 0; i < FB_N; i++) if (ram[i] !== ref_fb[i]) bad++;
    chk(nm, 32'(bad), 32'd0);
  endtask

  initial begin
    int n, bad;
    for (int i = 0; i < FB_N; i++) ref_fb[i] = pat(i);
    rst = 1; blanking = 1; x = '0; y = '0; wr_valid = 0; wr_addr = '0;
    wr_data = '0; clear_req = 0; clear_color = '0;

    // Reset, then idle blanking.
    repeat (3) cycle();
    rst = 0;
    repeat (4) cycle();

    // One scanned line segment: F00 for 4 cycles, then 0F0.
    blanking = 0; y = 9'd0;
    for (int i = 0; i < 8; i++) begin x = 10'(i); cycle(); end
    blanking = 1; x = 10'd640;
    repeat (3) cycle();

    // Writes contending with active video.
    blanking = 0; y = 9'd32; wr_valid = 1; wr_addr = 15'd100; wr_data = 12'hABC;
    for (int i = 0; i < 16; i++) begin x = 10'(i); cycle(); end
    wr_valid = 0; blanking = 1;
    cycle();
    chk("ram100", 32'(ram[100]), 32'h0ABC);

    // Out-of-range writes in blanking: acknowledged, not written.
    wr_valid = 1; wr_data = 12'h123;
    wr_addr = 15'(FB_N); repeat (3) cycle();
    wr_addr = 15'h7FFF; cycle();
    wr_valid = 0; cycle();
    ram_vs_ref("oor_ram");

    // Random raster fragments and writes.
    repeat (60) begin
      int len, xs, ys;
      len = int'($urandom_range(4, 40));
      if ($urandom_range(0, 1) == 1) begin
        xs = int'($urandom_range(0, 600)); ys = int'($urandom_range(0, 479));
        for (int k = 0; k < len && xs + k < 640; k++) begin
          blanking = 0; x = 10'(xs + k); y = 9'(ys); rand_wr(); cycle();
        end
      end else begin
        for (int k = 0; k < len; k++) begin
          blanking = 1; x = 10'($urandom_range(0, 799)); y = 9'($urandom_range(0, 511));
          rand_wr(); cycle();
        end
      end
    end
    blanking = 1; wr_valid = 0; cycle();
    ram_vs_ref("rand_ram");

    // Full clear with background traffic; a second request mid-clear is ignored.
    clear_req = 1; clear_color = 12'h00F; cycle();
    clear_req = 0;
    n = 0;
    while (m_busy && n < 40000) begin
      blanking = ($urandom_range(0, 3) != 0);
      x = 10'($urandom_range(0, 639)); y = 9'($urandom_range(0, 479));
      rand_wr();
      if (n == 5000) begin clear_req = 1; clear_color = 12'h777; end
      cycle();
      clear_req = 0;
      n++;
    end
    blanking = 1; wr_valid = 0;
    repeat (2) cycle();
    chk("clear_done", 32'(clear_busy), 32'd0);
    bad = 0;
    for (int i = 0; i < FB_N; i++) if (ram[i] !== 12'h00F) bad++;
    chk("clear_fill", 32'(bad), 32'd0);
    ram_vs_ref("clear_ram");

    // Abort a clear with reset, then restart from address 0.
    clear_req = 1; clear_color = 12'h0A0; cycle();
    clear_req = 0;
    repeat (1000) cycle();
    rst = 1; cycle();
    rst = 0; cycle();
    clear_req = 1; clear_color = 12'h5A5; cycle();
    clear_req = 0;
    repeat (300) cycle();
    chk("restart0", 32'(ram[0]), 32'h05A5);
    chk("abort500", 32'(ram[500]), 32'h00A0);
    chk("untouched", 32'(ram[5000]), 32'h000F);
    ram_vs_ref("restart_ram");

    repeat (2) cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
